// File: rtl/candy_wb_pkg.sv
// candy_wb_pkg: shared definitions for the candy_wb writeback stage.
//   RegBus / RegAddrBus : default register data / address widths
//   LD_BYTE/LD_HALF/LD_WORD : load size encodings (2'b11 is handled as word)
//   WriteEnable / ZeroWord  : register-file write constants
package candy_wb_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam logic [1:0] LD_BYTE = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_WORD = 2'b10;

  localparam logic              WriteEnable = 1'b1;
  localparam logic [RegBus-1:0] ZeroWord    = '0;

endpackage

// File: rtl/candy_wb_ldext.sv
// candy_wb_ldext: combinational load alignment and sign/zero extension.
// Ports:
//   rdata_i  raw memory word
//   off_i    byte offset (address[1:0])
//   size_i   LD_BYTE / LD_HALF / LD_WORD (2'b11 treated as word)
//   sgn_i    1 = sign-extend sub-word loads
//   data_o   aligned, extended load value
module candy_wb_ldext
  import candy_wb_pkg::*;
#(
  parameter int DATA_W = RegBus
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        off_i,
  input  logic [1:0]        size_i,
  input  logic              sgn_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] shifted;
  logic [7:0]        b;
  logic [15:0]       h;

  // A half at offset 3 simply takes whatever lands in [15:0] after the
  // shift (upper byte zero-filled); misalignment never traps here.
  assign shifted = rdata_i >> {off_i, 3'b000};
  assign b       = shifted[7:0];
  assign h       = shifted[15:0];

  always_comb begin
    data_o = shifted;
    case (size_i)
      LD_BYTE: data_o = {{(DATA_W-8){sgn_i & b[7]}}, b};
      LD_HALF: data_o = {{(DATA_W-16){sgn_i & h[15]}}, h};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/candy_wb.sv
// candy_wb: writeback stage in front of the register-file write port.
// Applies load extraction/extension to the MEM-stage result, arbitrates the
// single write port between the in-order pipeline and a late divider using a
// one-entry holding buffer, and counts retired instructions.
// Optional macro CANDY_WB_FWD_EN adds fwd_valid/fwd_addr/fwd_data, a
// combinational view of the write being registered this cycle.
// Ports:
//   clk, rst                       clock, async active-high reset
//   mem_*                          MEM-stage instruction and load controls
//   flush                          kill the MEM-stage instruction
//   div_valid/div_ready/div_waddr/div_data  divider result handshake
//   we, waddr, wdata               registered register-file write
//   retire_cnt                     retired instruction count
module candy_wb
  import candy_wb_pkg::*;
#(
  parameter int DATA_W = RegBus,
  parameter int ADDR_W = RegAddrBus,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_wreg,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              mem_is_load,
  input  logic [1:0]        mem_ld_size,
  input  logic              mem_ld_signed,
  input  logic [1:0]        mem_byte_off,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              flush,
  input  logic              div_valid,
  output logic              div_ready,
  input  logic [ADDR_W-1:0] div_waddr,
  input  logic [DATA_W-1:0] div_data,
`ifdef CANDY_WB_FWD_EN
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic [CNT_W-1:0]  retire_cnt
);

  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] pipe_data;
  logic              accept;
  logic              pipe_req;
  logic              div_fire;
  logic              div_keep;

  logic              hold_v_q, hold_v_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  candy_wb_ldext #(.DATA_W(DATA_W)) u_ldext (
    .rdata_i (mem_rdata),
    .off_i   (mem_byte_off),
    .size_i  (mem_ld_size),
    .sgn_i   (mem_ld_signed),
    .data_o  (ld_data)
  );

  assign pipe_data = mem_is_load ? ld_data : mem_result;
  assign accept    = mem_valid && !flush;
  assign pipe_req  = accept && mem_wreg && (mem_waddr != '0);
  assign div_ready = !hold_v_q;
  assign div_fire  = div_valid && div_ready;
  // The divider instruction is older: a same-cycle pipeline write to the
  // same register makes its result dead. x0 results are dropped too.
  assign div_keep  = div_fire && (div_waddr != '0) &&
                     !(pipe_req && (div_waddr == mem_waddr));

  always_comb begin
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    hold_v_d    = hold_v_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    cnt_d       = accept ? cnt_q + 1'b1 : cnt_q;

    if (pipe_req) begin
      we_d    = WriteEnable;
      waddr_d = mem_waddr;
      wdata_d = pipe_data;
      // Older buffered result to the same register would be overwritten.
      if (hold_v_q && (hold_addr_q == mem_waddr))
        hold_v_d = 1'b0;
      // div_fire implies the buffer was empty, so parking here is safe.
      if (div_keep) begin
        hold_v_d    = 1'b1;
        hold_addr_d = div_waddr;
        hold_data_d = div_data;
      end
    end else if (hold_v_q) begin
      we_d     = WriteEnable;
      waddr_d  = hold_addr_q;
      wdata_d  = hold_data_q;
      hold_v_d = 1'b0;
    end else if (div_keep) begin
      we_d    = WriteEnable;
      waddr_d = div_waddr;
      wdata_d = div_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_v_q    <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
    end else begin
      hold_v_q    <= hold_v_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign we         = we_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign retire_cnt = cnt_q;

`ifdef CANDY_WB_FWD_EN
  assign fwd_valid = we_d && (waddr_d != '0);
  assign fwd_addr  = waddr_d;
  assign fwd_data  = wdata_d;
`endif

endmodule

// File: tb/tb_candy_wb.sv
module tb_candy_wb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              mem_valid, mem_wreg, mem_is_load, mem_ld_signed, flush;
  logic [ADDR_W-1:0] mem_waddr, div_waddr;
  logic [DATA_W-1:0] mem_result, mem_rdata, div_data;
  logic [1:0]        mem_ld_size, mem_byte_off;
  logic              div_valid, div_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [CNT_W-1:0]  retire_cnt;
`ifdef CANDY_WB_FWD_EN
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;
`endif

  int checks   = 0;
  int failures = 0;
  int ecnt     = 0;

  candy_wb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_valid     (mem_valid),
    .mem_wreg      (mem_wreg),
    .mem_waddr     (mem_waddr),
    .mem_result    (mem_result),
    .mem_is_load   (mem_is_load),
    .mem_ld_size   (mem_ld_size),
    .mem_ld_signed (mem_ld_signed),
    .mem_byte_off  (mem_byte_off),
    .mem_rdata     (mem_rdata),
    .flush         (flush),
    .div_valid     (div_valid),
    .div_ready     (div_ready),
    .div_waddr     (div_waddr),
    .div_data      (div_data),
`ifdef CANDY_WB_FWD_EN
    .fwd_valid     (fwd_valid),
    .fwd_addr      (fwd_addr),
    .fwd_data      (fwd_data),
`endif
    .we            (we),
    .waddr         (waddr),
    .wdata         (wdata),
    .retire_cnt    (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    mem_valid = 0; mem_wreg = 0; mem_waddr = '0; mem_result = '0;
    mem_is_load = 0; mem_ld_size = 2'b00; mem_ld_signed = 0;
    mem_byte_off = 2'b00; mem_rdata = '0; flush = 0;
    div_valid = 0; div_waddr = '0; div_data = '0;
  endtask

  task automatic pipe(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] res);
    mem_valid = 1; mem_wreg = 1; mem_waddr = a; mem_result = res; mem_is_load = 0;
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [1:0] sz,
                      input logic sg, input logic [1:0] off);
    mem_valid = 1; mem_wreg = 1; mem_waddr = a; mem_is_load = 1;
    mem_ld_size = sz; mem_ld_signed = sg; mem_byte_off = off;
    mem_rdata = 32'h80FF7F01; mem_result = 32'hDEAD0000;
  endtask

  task automatic div(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    div_valid = 1; div_waddr = a; div_data = d;
  endtask

  // Advance one edge; the model counter follows accepted instructions.
  task automatic tick();
    if (mem_valid && !flush) ecnt++;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic chk_wr(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    chk({tag, "_we"}, 64'(we), 64'd1);
    chk({tag, "_addr"}, 64'(waddr), 64'(a));
    chk({tag, "_data"}, 64'(wdata), 64'(d));
  endtask

  initial begin
    idle();
    rst = 1;
    #1;
    chk("rst_we", 64'(we), 0);
    chk("rst_waddr", 64'(waddr), 0);
    chk("rst_wdata", 64'(wdata), 0);
    chk("rst_cnt", 64'(retire_cnt), 0);
    chk("rst_ready", 64'(div_ready), 1);
    @(posedge clk); #1;
    rst = 0;

    // Load extraction: rdata 0x80FF7F01
    load(5, 2'b00, 1, 2'd2); tick(); chk_wr("lb_s_off2", 5, 32'hFFFFFFFF);
    load(5, 2'b00, 1, 2'd3); tick(); chk_wr("lb_s_off3", 5, 32'hFFFFFF80);
    load(6, 2'b00, 0, 2'd3); tick(); chk_wr("lb_u_off3", 6, 32'h00000080);
    load(6, 2'b00, 1, 2'd1); tick(); chk_wr("lb_s_off1", 6, 32'h0000007F);
    load(7, 2'b01, 1, 2'd2); tick(); chk_wr("lh_s_off2", 7, 32'hFFFF80FF);
    load(7, 2'b01, 0, 2'd1); tick(); chk_wr("lh_u_off1", 7, 32'h0000FF7F);
    load(8, 2'b10, 0, 2'd0); tick(); chk_wr("lw", 8, 32'h80FF7F01);
    load(8, 2'b11, 1, 2'd0); tick(); chk_wr("lw_sz3", 8, 32'h80FF7F01);
    pipe(9, 32'h12345678);   tick(); chk_wr("alu", 9, 32'h12345678);
    chk("cnt_after_loads", 64'(retire_cnt), 64'(ecnt % 16));

    // Collision: pipeline wins, divider parked then drained
    pipe(3, 32'h11); div(7, 32'h22); tick();
    chk_wr("coll_c1", 3, 32'h11);
    chk("coll_c1_ready", 64'(div_ready), 0);
    tick();
    chk_wr("coll_c2", 7, 32'h22);
    chk("coll_c2_ready", 64'(div_ready), 1);
    tick();
    chk("coll_idle_we", 64'(we), 0);
    chk("coll_idle_addr", 64'(waddr), 7);

    // WAW: buffered r4 dropped by younger pipeline write to r4
    pipe(9, 32'h99); div(4, 32'hAA); tick();
    chk_wr("waw_c1", 9, 32'h99);
    pipe(4, 32'hBB); tick();
    chk_wr("waw_c2", 4, 32'hBB);
    chk("waw_ready", 64'(div_ready), 1);
    tick();
    chk("waw_no_late_we", 64'(we), 0);
    chk("waw_hold_data", 64'(wdata), 32'hBB);

    // Same-cycle divider to the pipeline's register is discarded
    pipe(6, 32'h66); div(6, 32'h77); tick();
    chk_wr("samec", 6, 32'h66);
    chk("samec_ready", 64'(div_ready), 1);
    tick();
    chk("samec_no_late_we", 64'(we), 0);

    // Divider alone bypasses the buffer; divider to x0 dropped
    div(8, 32'h88); tick();
    chk_wr("div_direct", 8, 32'h88);
    chk("div_direct_ready", 64'(div_ready), 1);
    div(0, 32'h5); tick();
    chk("div_x0_we", 64'(we), 0);
    chk("div_x0_ready", 64'(div_ready), 1);

    // x0 write retires but does not write
    pipe(0, 32'h1); tick();
    chk("x0_we", 64'(we), 0);
    chk("x0_cnt", 64'(retire_cnt), 64'(ecnt % 16));

    // Flush: instruction dropped, buffer still drains
    pipe(10, 32'hA0); div(11, 32'hB1); tick();
    chk_wr("fl_c1", 10, 32'hA0);
    pipe(12, 32'hC2); flush = 1; tick();
    chk_wr("fl_drain", 11, 32'hB1);
    chk("fl_cnt", 64'(retire_cnt), 64'(ecnt % 16));
    tick();
    chk("fl_idle_we", 64'(we), 0);

    // Async reset between edges while the buffer is full
    pipe(13, 32'hD3); div(14, 32'hE4); tick();
    chk("ar_ready_full", 64'(div_ready), 0);
    chk("ar_we_before", 64'(we), 1);
    #2; rst = 1; #1;
    ecnt = 0;
    chk("ar_we", 64'(we), 0);
    chk("ar_cnt", 64'(retire_cnt), 0);
    chk("ar_ready", 64'(div_ready), 1);
    @(posedge clk); #1;
    rst = 0;
    tick();
    chk("ar_no_write", 64'(we), 0);
    tick();
    chk("ar_no_write2", 64'(we), 0);

    // Counter wrap at CNT_W=4: 17 accepted instructions
    for (int i = 0; i < 17; i++) begin
      mem_valid = 1; mem_wreg = i[0]; mem_waddr = 5'd1; mem_result = 32'(i);
      tick();
    end
    chk("wrap_cnt", 64'(retire_cnt), 1);
    chk("wrap_model", 64'(retire_cnt), 64'(ecnt % 16));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
